// File: rtl/branch_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_hazard_ctrl_pkg
// Description : Shared encodings for the branch hazard controller: branch
//               types decoded in ID, FSM state codes, the hard-wired zero
//               register, and a helper that decides whether a producer's
//               destination feeds the branch in ID.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_hazard_ctrl_pkg;

    // Branch type carried on ID_Branch
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JR   = 2'b11;

    // Controller states
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // $0 is hard-wired to zero, so writes to it never create a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when register rd is read by the branch in ID. jr only reads rs.
    function automatic logic reg_used(input logic [1:0] br_type,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt);
        logic w_br;
        w_br = (br_type != BR_NONE);
        return w_br && (rd != REG_ZERO) &&
               ((rd == rs) || ((br_type != BR_JR) && (rd == rt)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//   clk       - clock
//   reset     - asynchronous active-high clear
//   increment - count one when high
//   count     - current value (WIDTH bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (increment && (r_count != '1)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_hazard_ctrl
// Description : Stall / flush control for branches resolved in ID.
//   Inputs : ID_Branch, ID_Jump, ID_rs, ID_rt   - branch in ID
//            ID_EX_RegWrite/MemRead/rd           - producer in EX
//            EX_MEM_MemRead/rd                   - producer in MEM
//            PCSrc                               - branch-taken decision
//   Outputs: PCWrite, IF_ID_Write (0 = hold), ID_EX_Bubble, IF_ID_Flush,
//            stall_count, flush_count (saturating), busy (in STALL)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int DELAY_SLOT = 0,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ID_Branch,
    input  logic             ID_Jump,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             PCSrc,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             busy
);

    logic [0:0] r_state;
    logic [1:0] r_cnt;
    logic [0:0] w_state_nxt;
    logic [1:0] w_cnt_nxt;
    logic [1:0] w_need;
    logic       w_br;
    logic       w_ex_used;
    logic       w_mem_used;
    logic       w_redirect;
    logic       w_stall;
    logic       w_flush;

    assign w_br       = (ID_Branch != BR_NONE);
    assign w_ex_used  = reg_used(ID_Branch, ID_EX_rd, ID_rs, ID_rt);
    assign w_mem_used = reg_used(ID_Branch, EX_MEM_rd, ID_rs, ID_rt);

    // Priority: a load in EX needs two bubbles before its data can be
    // forwarded into ID; an ALU result in EX or a load in MEM needs one.
    always_comb begin
        w_need = 2'd0;
        if (ID_EX_MemRead && w_ex_used) begin
            w_need = 2'd2;
        end else if (ID_EX_RegWrite && w_ex_used) begin
            w_need = 2'd1;
        end else if (EX_MEM_MemRead && w_mem_used) begin
            w_need = 2'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == ST_STALL) begin
            // Hazard inputs are ignored while the pending count drains
            w_cnt_nxt = (r_cnt != 2'd0) ? (r_cnt - 2'd1) : 2'd0;
            if (r_cnt <= 2'd1) begin
                w_state_nxt = ST_RUN;
            end
        end else if (w_need != 2'd0) begin
            w_cnt_nxt = w_need - 2'd1;
            if (w_need == 2'd2) begin
                w_state_nxt = ST_STALL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are gated with reset so they take their idle values
    // immediately, even while hazard inputs are still active.
    assign w_stall    = !reset && ((r_state == ST_STALL) || (w_need != 2'd0));
    assign w_redirect = ID_Jump || (w_br && PCSrc) || (ID_Branch == BR_JR);
    // A stalled branch is not resolved yet; its flush follows the stall.
    assign w_flush    = !reset && w_redirect && !w_stall && (DELAY_SLOT == 0);

    assign PCWrite      = !w_stall;
    assign IF_ID_Write  = !w_stall;
    assign ID_EX_Bubble = w_stall;
    assign IF_ID_Flush  = w_flush;
    assign busy         = !reset && (r_state == ST_STALL);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk       (clk),
        .reset     (reset),
        .increment (w_stall),
        .count     (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk       (clk),
        .reset     (reset),
        .increment (w_flush),
        .count     (flush_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_hazard_ctrl
// Description : Directed bench. u_dut0 has DELAY_SLOT=0, CNT_W=32; u_dut1
//               has DELAY_SLOT=1, CNT_W=4 and shares every input, so the
//               delay-slot and saturation behaviour are observed alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ID_Branch;
    logic       ID_Jump;
    logic [4:0] ID_rs, ID_rt;
    logic       ID_EX_RegWrite, ID_EX_MemRead;
    logic [4:0] ID_EX_rd;
    logic       EX_MEM_MemRead;
    logic [4:0] EX_MEM_rd;
    logic       PCSrc;

    logic        pcw0, ifw0, bub0, fl0, busy0;
    logic [31:0] sc0, fc0;
    logic        pcw1, ifw1, bub1, fl1, busy1;
    logic [3:0]  sc1, fc1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.DELAY_SLOT(0), .CNT_W(32)) u_dut0 (
        .clk(clk), .reset(reset), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd), .PCSrc(PCSrc),
        .PCWrite(pcw0), .IF_ID_Write(ifw0), .ID_EX_Bubble(bub0),
        .IF_ID_Flush(fl0), .stall_count(sc0), .flush_count(fc0), .busy(busy0)
    );

    branch_hazard_ctrl #(.DELAY_SLOT(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd), .PCSrc(PCSrc),
        .PCWrite(pcw1), .IF_ID_Write(ifw1), .ID_EX_Bubble(bub1),
        .IF_ID_Flush(fl1), .stall_count(sc1), .flush_count(fc1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stall-output triple for u_dut0 packed as {PCWrite, IF_ID_Write, Bubble}
    task automatic check_ctl(input string tag, input logic stall);
        check(tag, {29'd0, pcw0, ifw0, bub0},
              stall ? 32'b001 : 32'b110);
    endtask

    task automatic drive(input logic [1:0] br, input logic jmp,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic exw, input logic exm, input logic [4:0] exrd,
                         input logic memm, input logic [4:0] memrd,
                         input logic pcs);
        ID_Branch = br; ID_Jump = jmp; ID_rs = rs; ID_rt = rt;
        ID_EX_RegWrite = exw; ID_EX_MemRead = exm; ID_EX_rd = exrd;
        EX_MEM_MemRead = memm; EX_MEM_rd = memrd; PCSrc = pcs;
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with an active hazard and jump on the inputs
        reset = 1'b1;
        drive(2'b01, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b0, 5'd0, 1'b1);
        tick(); tick();
        check_ctl("reset_ctl", 1'b0);
        check("reset_flush", {31'd0, fl0}, 32'd0);
        check("reset_busy", {31'd0, busy0}, 32'd0);
        check("reset_stall_cnt", sc0, 32'd0);
        check("reset_flush_cnt", fc0, 32'd0);
        drive(2'b00, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;
        tick();
        check_ctl("idle_ctl", 1'b0);

        // ALU hazard: slt $1 in EX, beq $1,$0 taken
        drive(2'b01, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b0, 5'd0, 1'b1);
        #1;
        check_ctl("alu_stall", 1'b1);
        check("alu_noflush", {31'd0, fl0}, 32'd0);
        check("alu_busy", {31'd0, busy0}, 32'd0);
        tick();
        drive(2'b01, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
        #1;
        check_ctl("alu_resolve", 1'b0);
        check("alu_flush", {31'd0, fl0}, 32'd1);
        check("alu_flush_ds1", {31'd0, fl1}, 32'd0);
        check("alu_stall_cnt", sc0, 32'd1);
        tick();
        drive(2'b00, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("alu_flush_cnt", fc0, 32'd1);
        check("alu_flush_1cyc", {31'd0, fl0}, 32'd0);

        // Load hazard: lw $2 in EX, bne $2,$3
        drive(2'b10, 1'b0, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0);
        #1;
        check_ctl("ld_stall1", 1'b1);
        check("ld_busy1", {31'd0, busy0}, 32'd0);
        tick();
        // Second cycle: no hazard on inputs plus a jump; both must be ignored
        drive(2'b00, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check_ctl("ld_stall2", 1'b1);
        check("ld_busy2", {31'd0, busy0}, 32'd1);
        check("ld_noflush2", {31'd0, fl0}, 32'd0);
        tick();
        drive(2'b00, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check_ctl("ld_done", 1'b0);
        check("ld_busy3", {31'd0, busy0}, 32'd0);
        check("ld_stall_cnt", sc0, 32'd3);

        // Register zero: write to $0 in EX, beq $0,$0
        drive(2'b01, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        #1;
        check_ctl("r0_nostall", 1'b0);
        check("r0_flush", {31'd0, fl0}, 32'd1);
        tick();
        check("r0_flush_cnt", fc0, 32'd2);

        // jr $31 with lw $31 in MEM
        drive(2'b11, 1'b0, 5'd31, 5'd31, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b0);
        #1;
        check_ctl("jr_stall", 1'b1);
        check("jr_noflush", {31'd0, fl0}, 32'd0);
        check("jr_ds1_stall", {31'd0, pcw1}, 32'd0);
        tick();
        drive(2'b11, 1'b0, 5'd31, 5'd31, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check_ctl("jr_resolve", 1'b0);
        check("jr_flush", {31'd0, fl0}, 32'd1);
        check("jr_ds1_noflush", {31'd0, fl1}, 32'd0);
        tick();
        check("jr_stall_cnt", sc0, 32'd4);
        check("jr_flush_cnt", fc0, 32'd3);
        check("ds1_stall_cnt", {28'd0, sc1}, 32'd4);
        check("ds1_flush_cnt", {28'd0, fc1}, 32'd0);

        // jr ignores rt: EX writes $6 = rt only
        drive(2'b11, 1'b0, 5'd5, 5'd6, 1'b1, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0);
        #1;
        check_ctl("jr_rt_nostall", 1'b0);
        check("jr_rt_flush", {31'd0, fl0}, 32'd1);
        tick();

        // j alone never stalls, even when its fields alias an EX write
        drive(2'b00, 1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0);
        #1;
        check_ctl("jump_nostall", 1'b0);
        check("jump_flush", {31'd0, fl0}, 32'd1);
        tick();
        check("jump_flush_cnt", fc0, 32'd5);

        // Saturation on the 4-bit counters: 20 consecutive ALU stalls
        drive(2'b01, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        check("sat_reach", {28'd0, sc1}, 32'd15);
        for (int i = 0; i < 9; i++) tick();
        check("sat_hold", {28'd0, sc1}, 32'd15);
        check("sat_wide_cnt", sc0, 32'd24);

        // Reset in the middle of STALL
        drive(2'b10, 1'b0, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0);
        tick();
        check("mid_busy", {31'd0, busy0}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_ctl("mid_rst_ctl", 1'b0);
        check("mid_rst_busy", {31'd0, busy0}, 32'd0);
        check("mid_rst_cnt", sc0, 32'd0);
        tick();
        drive(2'b00, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;
        tick();
        check_ctl("post_rst_ctl", 1'b0);
        check("post_rst_busy", {31'd0, busy0}, 32'd0);
        check("post_rst_stall_cnt", sc0, 32'd0);
        check("post_rst_flush_cnt", fc0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
